// File: rtl/multicycle_control.sv
// Multicycle MIPS-style datapath controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with optional memory wait handshaking.
module multicycle_control #(
  parameter int MEM_WAIT_EN = 1,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OP,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWr,
  output logic               IorD,
  output logic               MemRd,
  output logic               MemWr,
  output logic               IRWr,
  output logic               RegWr,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               ExtOp,
  output logic               illegal,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [3:0]         state
);
  // state | meaning
  // IF    | fetch instruction, PC += 4 (waits for memory)
  // ID    | decode OP, precompute branch target
  // EXE_R | R-type ALU operation
  // EXE_I | ori / addiu ALU operation
  // MADDR | lw / sw address computation
  // MRD   | data memory read (waits for memory)
  // MWR   | data memory write (waits for memory)
  // WB    | register file write-back
  // BR    | beq / bne compare and conditional PC update
  // JMP   | jump PC update

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EXE_R = 4'd2,
    S_EXE_I = 4'd3,
    S_MADDR = 4'd4,
    S_MRD   = 4'd5,
    S_MWR   = 4'd6,
    S_WB    = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b100;

  localparam logic WAIT_EN = (MEM_WAIT_EN != 0);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       ready;
  logic       op_legal;
  logic       pc_wr_raw, mem_rd_raw, mem_wr_raw, ir_wr_raw, reg_wr_raw;
  logic [2:0] alu_op3;

  assign ready = mem_ready | ~WAIT_EN;
  assign state = state_q;

  always_comb begin
    op_legal = 1'b0;
    case (OP)
      OP_R, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= OP;
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = ready ? S_ID : S_IF;
      S_ID: begin
        case (OP)
          OP_R:             state_d = S_EXE_R;
          OP_ORI, OP_ADDIU: state_d = S_EXE_I;
          OP_LW, OP_SW:     state_d = S_MADDR;
          OP_BEQ, OP_BNE:   state_d = S_BR;
          OP_J:             state_d = S_JMP;
          default:          state_d = S_IF;
        endcase
      end
      S_EXE_R, S_EXE_I: state_d = S_WB;
      S_MADDR: begin
        if (op_q == OP_LW)      state_d = S_MRD;
        else if (op_q == OP_SW) state_d = S_MWR;
        else                    state_d = S_IF;
      end
      S_MRD:   state_d = ready ? S_WB : S_MRD;
      S_MWR:   state_d = ready ? S_IF : S_MWR;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_wr_raw  = 1'b0;
    mem_rd_raw = 1'b0;
    mem_wr_raw = 1'b0;
    ir_wr_raw  = 1'b0;
    reg_wr_raw = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ExtOp      = 1'b0;
    illegal    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    alu_op3    = ALU_ADD;
    case (state_q)
      S_IF: begin
        mem_rd_raw = 1'b1;
        ALUSrcB    = 2'b01;
        ir_wr_raw  = ready;
        pc_wr_raw  = ready;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        illegal = ~op_legal;
      end
      S_EXE_R: begin
        ALUSrcA = 1'b1;
        alu_op3 = ALU_FUNCT;
      end
      S_EXE_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op_q == OP_ORI) begin
          alu_op3 = ALU_OR;
          ExtOp   = 1'b0;
        end else begin
          alu_op3 = ALU_ADD;
          ExtOp   = 1'b1;
        end
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MRD: begin
        mem_rd_raw = 1'b1;
        IorD       = 1'b1;
      end
      S_MWR: begin
        IorD       = 1'b1;
        mem_wr_raw = ready;
      end
      S_WB: begin
        reg_wr_raw = 1'b1;
        RegDst     = (op_q == OP_R);
        MemtoReg   = (op_q == OP_LW);
      end
      S_BR: begin
        ALUSrcA   = 1'b1;
        alu_op3   = ALU_SUB;
        PCSrc     = 2'b01;
        pc_wr_raw = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
      end
      S_JMP: begin
        PCSrc     = 2'b10;
        pc_wr_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are masked by reset directly so nothing fires while rst_n is low.
  assign PCWr  = pc_wr_raw  & rst_n;
  assign MemRd = mem_rd_raw & rst_n;
  assign MemWr = mem_wr_raw & rst_n;
  assign IRWr  = ir_wr_raw  & rst_n;
  assign RegWr = reg_wr_raw & rst_n;

  always_comb begin
    ALUop      = '0;
    ALUop[2:0] = alu_op3;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter ALUOP_W, default 3, meaning: ALUop width; must be at least 3, and upper bits are driven 0.
REQ-003 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port OP, input, 6 bits: opcode field of the instruction register; sampled only in state ID.
REQ-006 Port zero, input, 1 bit: ALU zero flag; used only in state BR.
REQ-007 Port mem_ready, input, 1 bit: the memory access completes in the current cycle.
REQ-008 Outputs, 1 bit each: PCWr, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA, ExtOp, illegal.
REQ-009 Outputs ALUSrcB (2 bits), PCSrc (2 bits), ALUop (ALUOP_W bits), state (4 bits, debug).

Function
REQ-010 The block SHALL be a Moore FSM with an internal 6-bit opcode register op_q, loaded from OP on leaving state ID.
REQ-011 State encoding SHALL be: IF=0, ID=1, EXE_R=2, EXE_I=3, MADDR=4, MRD=5, MWR=6, WB=7, BR=8, JMP=9; codes 10-15 SHALL return to IF on the next edge.
REQ-012 Decoded opcodes SHALL be: R_type 000000, ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
REQ-013 State transitions SHALL be:
  - IF->ID when ready.
  - ID->EXE_R for R_type; ID->EXE_I for ori/addiu; ID->MADDR for lw/sw; ID->BR for beq/bne; ID->JMP for j; ID->IF for any other opcode.
  - EXE_R->WB; EXE_I->WB.
  - MADDR->MRD for lw; MADDR->MWR for sw.
  - MRD->WB when ready; MWR->IF when ready.
  - WB->IF; BR->IF; JMP->IF.
REQ-014 "ready" SHALL mean (mem_ready | !MEM_WAIT_EN); IF, MRD and MWR SHALL hold state while not ready.
REQ-015 IF SHALL assert MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=add, PCSrc=00; IRWr and PCWr SHALL equal ready.
REQ-016 ID SHALL assert ALUSrcA=0, ALUSrcB=11, ALUop=add, ExtOp=1 (branch-target precompute).
REQ-017 EXE_R SHALL assert ALUSrcA=1, ALUSrcB=00, ALUop=funct.
REQ-018 EXE_I SHALL assert ALUSrcA=1, ALUSrcB=10, with ALUop=or and ExtOp=0 for ori, and ALUop=add and ExtOp=1 for addiu.
REQ-019 MADDR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUop=add, ExtOp=1.
REQ-020 MRD SHALL assert MemRd=1, IorD=1; MWR SHALL assert IorD=1 and MemWr=ready.
REQ-021 WB SHALL assert RegWr=1, with RegDst=1 for R_type and MemtoReg=1 for lw, otherwise 0.
REQ-022 BR SHALL assert ALUSrcA=1, ALUSrcB=00, ALUop=sub, PCSrc=01, and PCWr=(beq&zero)|(bne&!zero).
REQ-023 JMP SHALL assert PCSrc=10 and PCWr=1.
REQ-024 ALUop encodings SHALL be: add=000, funct=001, or=010, sub=100.
REQ-025 Every output not listed for a state SHALL be 0 in that state.
REQ-026 illegal SHALL be 1 for exactly the ID cycle holding an undecoded opcode; no write enable SHALL be asserted for that instruction.
REQ-027 Latency with ready held high SHALL be: R_type/ori/addiu/sw 4 cycles, lw 5, beq/bne/j 3.
REQ-028 OP changes after ID SHALL NOT affect the current instruction.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IF and op_q=0.
REQ-030 rst_n=0 SHALL combinationally force PCWr, MemRd, MemWr, IRWr and RegWr to 0, including mid-instruction.
REQ-031 After rst_n rises, the first rising clk edge SHALL execute IF normally.

Verification
REQ-032 R-type: OP=000000, mem_ready=1 -> state 0,1,2,7,0; RegWr=1 and RegDst=1 only in cycle 4; ALUop=001 in cycle 3.
REQ-033 lw with wait: OP=100011, mem_ready low for 2 cycles in MRD -> state stays 5 for 3 cycles, then 7 with MemtoReg=1; total 7 cycles.
REQ-034 beq/bne: beq with zero=1 -> PCWr=1 and PCSrc=01 in BR; bne with zero=1 -> PCWr=0; bne with zero=0 -> PCWr=1.
REQ-035 Illegal opcode: OP=111111 -> illegal=1 in ID, next state IF, no RegWr or MemWr asserted.
REQ-036 Reset mid-sw: rst_n driven low while state=MWR and mem_ready=0 -> MemWr=0 and state=0 immediately, without waiting for clk.
REQ-037 MEM_WAIT_EN=0: mem_ready tied 0, sw -> completes in 4 cycles with MemWr=1 in MWR.
